// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet rx/tx byte-stream blocks.
// State encoding for the rx front end plus CRC-32 (IEEE 802.3, reflected) constants.
package eth_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRE,
      DATA,
      DROP
   } rx_state_t;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;

   localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
   // Register value left after running the CRC over payload plus its own FCS
   localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

   localparam int          LEN_W         = 11;
   localparam logic [LEN_W-1:0] LEN_SAT  = '1;

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational CRC-32 step for one byte, LSB-first, reflected polynomial; no register.
// Shared by the rx FCS checker and the tx FCS appender.
module eth_crc32_d8
   import eth_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);

   always_comb begin
      crc_out = crc_in ^ {24'h0, data};
      for (int i = 0; i < 8; i++) begin
         crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC_POLY) : (crc_out >> 1);
      end
   end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// Rx front end: strips preamble/SFD, checks FCS and length, forwards payload minus FCS.
// Byte n appears one cycle after byte n+4 is sampled; no back-pressure, one byte per cycle.
module eth_rx_fcs_check
   import eth_pkg::*;
#(
   parameter int unsigned MIN_FRAME = 64,
   parameter int unsigned MAX_FRAME = 1518
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       i_data,
   input  logic             i_data_vl,
   output logic [7:0]       o_data,
   output logic             o_data_vl,
   output logic             o_done,
   output logic             o_fcs_ok,
   output logic [LEN_W-1:0] o_len,
   output logic [15:0]      o_good_cnt,
   output logic [15:0]      o_bad_cnt
);

   localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_FRAME);
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME);

   rx_state_t         state, state_nxt;
   logic [31:0]       crc_q, crc_upd;
   logic [LEN_W-1:0]  len_q, len_inc;
   logic [3:0][7:0]   dl_q;
   logic [2:0]        dl_cnt;
   logic              drop_rep;
   logic              sfd_seen, len_over, frame_end, verdict;

   eth_crc32_d8 u_crc (
      .crc_in  (crc_q),
      .data    (i_data),
      .crc_out (crc_upd)
   );

   always_comb begin
      state_nxt = state;
      sfd_seen  = 1'b0;
      len_over  = (len_q >= MAX_LEN);
      len_inc   = (len_q == LEN_SAT) ? len_q : len_q + LEN_W'(1);
      frame_end = 1'b0;
      verdict   = (state == DATA) && (crc_q == CRC_RESIDUE) &&
                  (len_q >= MIN_LEN) && (len_q <= MAX_LEN);
      case (state)
         IDLE, PRE: begin
            if (!i_data_vl) begin
               state_nxt = IDLE;
            end else if (i_data == PREAMBLE_BYTE) begin
               state_nxt = PRE;
            end else if (i_data == SFD_BYTE) begin
               state_nxt = DATA;
               sfd_seen  = 1'b1;
            end else begin
               state_nxt = DROP;
            end
         end
         DATA: begin
            if (!i_data_vl) begin
               state_nxt = IDLE;
               frame_end = 1'b1;
            end else if (len_over) begin
               state_nxt = DROP;
            end
         end
         DROP: begin
            if (!i_data_vl) begin
               state_nxt = IDLE;
               frame_end = drop_rep;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc_q      <= CRC_INIT;
         len_q      <= '0;
         dl_q       <= '0;
         dl_cnt     <= '0;
         drop_rep   <= 1'b0;
         o_data     <= '0;
         o_data_vl  <= 1'b0;
         o_done     <= 1'b0;
         o_fcs_ok   <= 1'b0;
         o_len      <= '0;
         o_good_cnt <= '0;
         o_bad_cnt  <= '0;
      end else begin
         o_data_vl <= 1'b0;
         o_done    <= 1'b0;

         if (sfd_seen) begin
            crc_q    <= CRC_INIT;
            len_q    <= '0;
            dl_cnt   <= '0;
            drop_rep <= 1'b0;
         end

         if (state == DATA && i_data_vl) begin
            crc_q <= crc_upd;
            len_q <= len_inc;
            if (len_over) begin
               // Oversize: stop forwarding now but keep counting so o_len reports the true size
               drop_rep <= 1'b1;
            end else begin
               dl_q <= {dl_q[2:0], i_data};
               if (dl_cnt == 3'd4) begin
                  o_data    <= dl_q[3];
                  o_data_vl <= 1'b1;
               end else begin
                  dl_cnt <= dl_cnt + 3'd1;
               end
            end
         end

         if (state == DROP && i_data_vl && drop_rep) begin
            len_q <= len_inc;
         end

         if (frame_end) begin
            o_done   <= 1'b1;
            o_fcs_ok <= verdict;
            o_len    <= len_q;
            drop_rep <= 1'b0;
            if (verdict) begin
               o_good_cnt <= o_good_cnt + 16'd1;
            end else begin
               o_bad_cnt  <= o_bad_cnt + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Bench for eth_rx_fcs_check: directed and random frames against a byte-level frame model.
module tb_eth_rx_fcs_check;

   typedef logic [7:0] bq_t[$];

   localparam int MINF = 64;
   localparam int MAXF = 1518;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  i_data;
   logic        i_data_vl;
   logic [7:0]  o_data;
   logic        o_data_vl;
   logic        o_done;
   logic        o_fcs_ok;
   logic [10:0] o_len;
   logic [15:0] o_good_cnt;
   logic [15:0] o_bad_cnt;

   always #5 clk = ~clk;

   eth_rx_fcs_check #(.MIN_FRAME(MINF), .MAX_FRAME(MAXF)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_data     (i_data),
      .i_data_vl  (i_data_vl),
      .o_data     (o_data),
      .o_data_vl  (o_data_vl),
      .o_done     (o_done),
      .o_fcs_ok   (o_fcs_ok),
      .o_len      (o_len),
      .o_good_cnt (o_good_cnt),
      .o_bad_cnt  (o_bad_cnt)
   );

   logic [7:0]  out_q[$];
   int          done_cnt = 0;
   logic        last_ok;
   logic [10:0] last_len;

   always @(negedge clk) begin
      if (o_data_vl) out_q.push_back(o_data);
      if (o_done) begin
         done_cnt = done_cnt + 1;
         last_ok  = o_fcs_ok;
         last_len = o_len;
      end
   end

   int          total = 0;
   int          bad = 0;
   int          exp_good = 0;
   int          exp_bad = 0;
   logic [31:0] tbl[256];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, expv);
      end
   endtask

   // Standard table-driven CRC-32 (final complement included)
   function automatic logic [31:0] crc32(input bq_t b, input int n);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < n; i++) c = (c >> 8) ^ tbl[c[7:0] ^ b[i]];
      return ~c;
   endfunction

   function automatic bq_t with_fcs(input bq_t p);
      bq_t         r;
      logic [31:0] c;
      r = p;
      c = crc32(p, p.size());
      for (int k = 0; k < 4; k++) r.push_back(c[8*k +: 8]);
      return r;
   endfunction

   function automatic bq_t rnd_payload(input int n, input bit arp);
      bq_t r;
      for (int i = 0; i < n; i++) r.push_back(8'($urandom_range(0, 255)));
      if (arp && n >= 14) begin
         for (int i = 0; i < 6; i++) r[i] = 8'hFF;
         r[12] = 8'h08;
         r[13] = 8'h06;
      end
      return r;
   endfunction

   function automatic bq_t wrap(input bq_t f, input logic [7:0] sfd);
      bq_t r;
      for (int i = 0; i < 7; i++) r.push_back(8'h55);
      r.push_back(sfd);
      foreach (f[i]) r.push_back(f[i]);
      return r;
   endfunction

   // What a receiver must produce for the bytes following the SFD
   task automatic model(input bq_t f, output bq_t fwd, output logic ok, output logic [10:0] olen);
      int          n, nf;
      logic [31:0] c;
      n  = f.size();
      nf = ((n > MAXF) ? MAXF : n) - 4;
      if (nf < 0) nf = 0;
      fwd = {};
      for (int i = 0; i < nf; i++) fwd.push_back(f[i]);
      ok = 1'b0;
      if (n >= MINF && n <= MAXF) begin
         c  = crc32(f, n - 4);
         ok = (c == {f[n-1], f[n-2], f[n-3], f[n-4]});
      end
      olen = (n > 2047) ? 11'd2047 : 11'(n);
   endtask

   task automatic send(input bq_t raw);
      foreach (raw[i]) begin
         @(posedge clk); #1;
         i_data_vl = 1'b1;
         i_data    = raw[i];
      end
      @(posedge clk); #1;
      i_data_vl = 1'b0;
      i_data    = 8'h00;
   endtask

   task automatic check_out(input string tag, input bq_t efwd, input int start, input int d0,
                            input int ndone, input logic eok, input logic [10:0] elen);
      int mism;
      for (int i = 0; i < 20; i++) begin
         if (done_cnt - d0 >= ndone) break;
         @(negedge clk); #1;
      end
      chk({tag, " done"}, 64'(done_cnt - d0), 64'(ndone));
      chk({tag, " nbytes"}, 64'(out_q.size() - start), 64'(efwd.size()));
      mism = 0;
      for (int i = 0; i < efwd.size() && start + i < out_q.size(); i++)
         if (out_q[start+i] !== efwd[i]) mism++;
      chk({tag, " byte_mism"}, 64'(mism), 64'd0);
      chk({tag, " fcs_ok"}, 64'(last_ok), 64'(eok));
      chk({tag, " len"}, 64'(last_len), 64'(elen));
      chk({tag, " good_cnt"}, 64'(o_good_cnt), 64'(exp_good));
      chk({tag, " bad_cnt"}, 64'(o_bad_cnt), 64'(exp_bad));
   endtask

   task automatic run_frame(input string tag, input bq_t f);
      bq_t         efwd;
      logic        eok;
      logic [10:0] elen;
      int          start, d0;
      model(f, efwd, eok, elen);
      if (eok) exp_good++; else exp_bad++;
      start = out_q.size();
      d0    = done_cnt;
      send(wrap(f, 8'hD5));
      check_out(tag, efwd, start, d0, 1, eok, elen);
   endtask

   initial begin
      bq_t         f1, f2, fw1, fw2, raw;
      logic        ok1, ok2;
      logic [10:0] l1, l2;
      int          start, d0, p;

      for (int i = 0; i < 256; i++) begin
         logic [31:0] v;
         v = 32'(i);
         for (int k = 0; k < 8; k++) v = v[0] ? ((v >> 1) ^ 32'hEDB8_8320) : (v >> 1);
         tbl[i] = v;
      end

      rst = 1'b1; i_data = 8'h00; i_data_vl = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst o_data_vl", 64'(o_data_vl), 64'd0);
      chk("rst o_done", 64'(o_done), 64'd0);
      chk("rst o_data", 64'(o_data), 64'd0);
      chk("rst o_fcs_ok", 64'(o_fcs_ok), 64'd0);
      chk("rst o_len", 64'(o_len), 64'd0);
      chk("rst good", 64'(o_good_cnt), 64'd0);
      chk("rst bad", 64'(o_bad_cnt), 64'd0);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // Good 64-byte ARP frame, then the same with one payload bit flipped
      f1 = with_fcs(rnd_payload(60, 1'b1));
      run_frame("arp_good", f1);
      f2 = f1;
      f2[20] = f2[20] ^ 8'h10;
      run_frame("arp_flip", f2);

      // Bad SFD: silently dropped
      start = out_q.size();
      d0    = done_cnt;
      send(wrap(rnd_payload(40, 1'b0), 8'h5D));
      repeat (10) @(negedge clk);
      chk("badpre done", 64'(done_cnt - d0), 64'd0);
      chk("badpre nbytes", 64'(out_q.size() - start), 64'd0);
      chk("badpre good", 64'(o_good_cnt), 64'(exp_good));
      chk("badpre bad", 64'(o_bad_cnt), 64'(exp_bad));

      run_frame("runt", with_fcs(rnd_payload(30, 1'b0)));
      run_frame("short2", rnd_payload(2, 1'b0));
      run_frame("max1518", with_fcs(rnd_payload(1514, 1'b0)));
      run_frame("over1600", rnd_payload(1600, 1'b0));

      // Two good frames with a single idle cycle between them
      f1 = with_fcs(rnd_payload(60, 1'b0));
      f2 = with_fcs(rnd_payload(60, 1'b0));
      model(f1, fw1, ok1, l1);
      model(f2, fw2, ok2, l2);
      exp_good += 2;
      foreach (fw2[i]) fw1.push_back(fw2[i]);
      start = out_q.size();
      d0    = done_cnt;
      send(wrap(f1, 8'hD5));
      send(wrap(f2, 8'hD5));
      check_out("b2b", fw1, start, d0, 2, ok2, l2);

      // Async reset in the middle of a frame
      f1  = with_fcs(rnd_payload(60, 1'b0));
      raw = wrap(f1, 8'hD5);
      for (int i = 0; i < 28; i++) begin
         @(posedge clk); #1;
         i_data_vl = 1'b1;
         i_data    = raw[i];
      end
      @(posedge clk); #2;
      rst = 1'b1;
      i_data_vl = 1'b0;
      i_data = 8'h00;
      @(negedge clk);
      chk("midrst o_data_vl", 64'(o_data_vl), 64'd0);
      chk("midrst o_done", 64'(o_done), 64'd0);
      chk("midrst o_len", 64'(o_len), 64'd0);
      chk("midrst good", 64'(o_good_cnt), 64'd0);
      chk("midrst bad", 64'(o_bad_cnt), 64'd0);
      d0 = done_cnt;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_good = 0;
      exp_bad  = 0;
      repeat (5) @(negedge clk);
      chk("midrst no_done", 64'(done_cnt - d0), 64'd0);
      run_frame("after_rst", with_fcs(rnd_payload(60, 1'b0)));

      // Random lengths, some frames corrupted anywhere including the FCS
      for (int t = 0; t < 6; t++) begin
         f1 = with_fcs(rnd_payload($urandom_range(40, 200), 1'b0));
         if ($urandom_range(0, 1) == 1) begin
            p = $urandom_range(0, f1.size() - 1);
            f1[p] = f1[p] ^ (8'h01 << $urandom_range(0, 7));
         end
         run_frame($sformatf("rnd%0d", t), f1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
